// File: rtl/store_align_buffer.sv
// Store alignment buffer: lane-aligns byte/half/word stores onto 32-bit memory
// lanes and queues them for strictly in-order drain to data memory.
module store_align_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32,
  localparam int unsigned OPCODE_WIDTH = 2
) (
  input  logic                    sab_i_clk,
  input  logic                    sab_i_rst_n,
  input  logic                    sab_i_valid,
  output logic                    sab_o_ready,
  input  logic [OPCODE_WIDTH-1:0] sab_i_opcode,
  input  logic [AWIDTH-1:0]       sab_i_addr,
  input  logic [DWIDTH-1:0]       sab_i_data,
  output logic                    sab_o_misalign,
  output logic                    sab_o_empty,
  output logic                    sab_o_mem_valid,
  input  logic                    sab_i_mem_ready,
  output logic [AWIDTH-1:0]       sab_o_mem_addr,
  output logic [31:0]             sab_o_mem_data,
  output logic [3:0]              sab_o_mem_be,
  input  logic [AWIDTH-1:0]       sab_i_ld_addr,
  output logic                    sab_o_ld_hit
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [OPCODE_WIDTH-1:0] STORE_BYTE = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] STORE_HALF = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] STORE_WORD = OPCODE_WIDTH'(2);

  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;
  logic [AWIDTH-1:0] addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [3:0]        be_q   [DEPTH];
  logic              misalign_q;

  logic [1:0]  a_c;
  logic [31:0] d_c;
  logic        legal_c;
  logic        misalign_c;
  logic [3:0]  be_c;
  logic [31:0] lane_c;
  logic        push_c;
  logic        pop_c;

  assign a_c = sab_i_addr[1:0];
  assign d_c = 32'(sab_i_data);

  // Lane alignment and legality of the incoming request
  always_comb begin
    legal_c    = 1'b0;
    misalign_c = 1'b0;
    be_c       = 4'b0000;
    lane_c     = 32'h0;
    case (sab_i_opcode)
      STORE_BYTE: begin
        legal_c = 1'b1;
        be_c    = 4'b0001 << a_c;
        lane_c  = {4{d_c[7:0]}};
      end
      STORE_HALF: begin
        if (!a_c[0]) begin
          legal_c = 1'b1;
          be_c    = a_c[1] ? 4'b1100 : 4'b0011;
          lane_c  = {2{d_c[15:0]}};
        end else begin
          misalign_c = 1'b1;
        end
      end
      STORE_WORD: begin
        if (a_c == 2'b00) begin
          legal_c = 1'b1;
          be_c    = 4'b1111;
          lane_c  = d_c;
        end else begin
          misalign_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign sab_o_ready     = (count_q != FULL_COUNT);
  assign sab_o_empty     = (count_q == '0);
  assign sab_o_mem_valid = !sab_o_empty;
  assign push_c          = sab_i_valid && sab_o_ready && legal_c;
  assign pop_c           = sab_o_mem_valid && sab_i_mem_ready;

  // Pointer, occupancy and misalign-pulse state
  always_ff @(posedge sab_i_clk or negedge sab_i_rst_n) begin
    if (!sab_i_rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= sab_i_valid && misalign_c;
      if (push_c) tail_q <= tail_q + PW'(1);
      if (pop_c)  head_q <= head_q + PW'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // Entry storage; reset clears every entry so the head mux reads zero
  always_ff @(posedge sab_i_clk or negedge sab_i_rst_n) begin
    if (!sab_i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else if (push_c) begin
      addr_q[tail_q] <= sab_i_addr & ~AWIDTH'(3);
      data_q[tail_q] <= lane_c;
      be_q[tail_q]   <= be_c;
    end
  end

  assign sab_o_mem_addr = addr_q[head_q];
  assign sab_o_mem_data = data_q[head_q];
  assign sab_o_mem_be   = be_q[head_q];
  assign sab_o_misalign = misalign_q;

  // Word-address match against occupied slots only (offset from head < count)
  always_comb begin
    sab_o_ld_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(PW'(i) - head_q) < count_q) &&
          ((addr_q[i] >> 2) == (sab_i_ld_addr >> 2)))
        sab_o_ld_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
// Self-checking bench for store_align_buffer: vector table plus scoreboard of
// expected memory writes, with hand sequences for backpressure, wrap, hit and reset.
module tb_store_align_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned AWIDTH = 32;
  localparam int unsigned DWIDTH = 32;
  localparam logic [1:0] SB = 2'd0;
  localparam logic [1:0] SH = 2'd1;
  localparam logic [1:0] SW = 2'd2;
  localparam logic [1:0] SX = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        legal;
    logic        mis;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  logic              clk;
  logic              rst_n;
  logic              valid;
  logic              ready;
  logic [1:0]        opcode;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] data;
  logic              misalign;
  logic              empty;
  logic              mem_valid;
  logic              mem_ready;
  logic [AWIDTH-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic [3:0]        mem_be;
  logic [AWIDTH-1:0] ld_addr;
  logic              ld_hit;

  store_align_buffer #(.DEPTH(DEPTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
    .sab_i_clk       (clk),
    .sab_i_rst_n     (rst_n),
    .sab_i_valid     (valid),
    .sab_o_ready     (ready),
    .sab_i_opcode    (opcode),
    .sab_i_addr      (addr),
    .sab_i_data      (data),
    .sab_o_misalign  (misalign),
    .sab_o_empty     (empty),
    .sab_o_mem_valid (mem_valid),
    .sab_i_mem_ready (mem_ready),
    .sab_o_mem_addr  (mem_addr),
    .sab_o_mem_data  (mem_data),
    .sab_o_mem_be    (mem_be),
    .sab_i_ld_addr   (ld_addr),
    .sab_o_ld_hit    (ld_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ent_t sb_q[$];
  int   checks;
  int   errors;
  logic mis_exp;
  logic cur_legal;
  logic cur_mis;
  ent_t cur_ent;
  logic acc;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Mid-cycle model check; updates the scoreboard for the coming edge
  task automatic monitor();
    logic exp_hit;
    acc = 1'b0;
    if (!rst_n) begin
      sb_q.delete();
      mis_exp = 1'b0;
      chk("rst_mem_valid", 32'(mem_valid), 32'(0));
      chk("rst_empty", 32'(empty), 32'(1));
      chk("rst_ready", 32'(ready), 32'(1));
      chk("rst_misalign", 32'(misalign), 32'(0));
      chk("rst_ld_hit", 32'(ld_hit), 32'(0));
      return;
    end
    chk("empty", 32'(empty), 32'(sb_q.size() == 0));
    chk("ready", 32'(ready), 32'(sb_q.size() < DEPTH));
    chk("mem_valid", 32'(mem_valid), 32'(sb_q.size() != 0));
    chk("misalign", 32'(misalign), 32'(mis_exp));
    exp_hit = 1'b0;
    foreach (sb_q[i]) if (sb_q[i].addr[31:2] == ld_addr[31:2]) exp_hit = 1'b1;
    chk("ld_hit", 32'(ld_hit), 32'(exp_hit));
    if (sb_q.size() != 0) begin
      chk("head_addr", mem_addr, sb_q[0].addr);
      chk("head_data", mem_data, sb_q[0].data);
      chk("head_be", 32'(mem_be), 32'(sb_q[0].be));
    end
    mis_exp = valid && cur_mis;
    acc = valid && (sb_q.size() < DEPTH) && cur_legal;
    if (sb_q.size() != 0 && mem_ready) void'(sb_q.pop_front());
    if (acc) sb_q.push_back(cur_ent);
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0; cur_legal = 1'b0; cur_mis = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    valid = 1'b1; opcode = v.op; addr = v.addr; data = v.data;
    cur_legal = v.legal; cur_mis = v.mis;
    cur_ent.addr = v.waddr; cur_ent.data = v.wdata; cur_ent.be = v.be;
  endtask

  task automatic req_sw(input logic [31:0] a, input logic [31:0] d);
    vec_t v;
    v.op = SW; v.addr = a; v.data = d; v.legal = 1'b1; v.mis = 1'b0;
    v.waddr = a; v.wdata = d; v.be = 4'b1111;
    apply(v);
  endtask

  task automatic push_wait(input string name, input int bound);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc && n < bound);
    chk(name, 32'(acc), 32'(1));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    chk(name, 32'(sb_q.size()), 32'(0));
  endtask

  initial begin
    vecs[0]  = '{SB, 32'h1003, 32'h000000A5, 1, 0, 32'h1000, 32'hA5A5A5A5, 4'b1000};
    vecs[1]  = '{SH, 32'h2002, 32'h00001234, 1, 0, 32'h2000, 32'h12341234, 4'b1100};
    vecs[2]  = '{SW, 32'h2004, 32'hDEADBEEF, 1, 0, 32'h2004, 32'hDEADBEEF, 4'b1111};
    vecs[3]  = '{SH, 32'h2001, 32'h00005555, 0, 1, 32'h0,    32'h0,        4'b0000};
    vecs[4]  = '{SB, 32'h0010, 32'hFFFFFF3C, 1, 0, 32'h0010, 32'h3C3C3C3C, 4'b0001};
    vecs[5]  = '{SB, 32'h0011, 32'h00000077, 1, 0, 32'h0010, 32'h77777777, 4'b0010};
    vecs[6]  = '{SB, 32'h0012, 32'h0000005A, 1, 0, 32'h0010, 32'h5A5A5A5A, 4'b0100};
    vecs[7]  = '{SH, 32'h0020, 32'hABCD9876, 1, 0, 32'h0020, 32'h98769876, 4'b0011};
    vecs[8]  = '{SW, 32'h0022, 32'h11111111, 0, 1, 32'h0,    32'h0,        4'b0000};
    vecs[9]  = '{SW, 32'h0023, 32'h22222222, 0, 1, 32'h0,    32'h0,        4'b0000};
    vecs[10] = '{SX, 32'h0040, 32'h33333333, 0, 0, 32'h0,    32'h0,        4'b0000};
    vecs[11] = '{SH, 32'h0043, 32'h44444444, 0, 1, 32'h0,    32'h0,        4'b0000};

    checks = 0; errors = 0; mis_exp = 1'b0;
    rst_n = 1'b0; opcode = SB; addr = '0; data = '0;
    mem_ready = 1'b0; ld_addr = '0;
    cur_ent = '{32'h0, 32'h0, 4'h0};
    idle();
    #1;
    chk("reset_empty", 32'(empty), 32'(1));
    chk("reset_ready", 32'(ready), 32'(1));
    chk("reset_mem_valid", 32'(mem_valid), 32'(0));
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_data", mem_data, 32'h0);
    chk("reset_mem_be", 32'(mem_be), 32'(0));
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Alignment table, drained one entry per cycle
    mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i]);
      cycle();
    end
    idle();
    repeat (2) cycle();
    chk("table_drained", 32'(sb_q.size()), 32'(0));

    // Backpressure: fill, misalign while full, hold the fifth, then drain
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_sw(32'h100 + 32'(4 * k), 32'h11110000 + 32'(k));
      push_wait("fill_accept", 3);
    end
    apply(vecs[3]);
    cycle();
    req_sw(32'h110, 32'h55550005);
    repeat (3) begin
      cycle();
      chk("fifth_held", 32'(acc), 32'(0));
    end
    mem_ready = 1'b1;
    push_wait("fifth_accept", 10);
    idle();
    drain("full_drain");

    // Simultaneous push/pop with two queued, wrapping the pointers
    mem_ready = 1'b0;
    req_sw(32'h200, 32'hA0000000); push_wait("pp_pre0", 3);
    req_sw(32'h204, 32'hA0000001); push_wait("pp_pre1", 3);
    mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_sw(32'h208 + 32'(4 * k), 32'hB0000000 + 32'(k));
      push_wait("pp_accept", 2);
      chk("pp_mem_valid", 32'(mem_valid), 32'(1));
      chk("pp_ready", 32'(ready), 32'(1));
    end
    idle();
    drain("pp_drain");

    // Load hit against a pending store
    mem_ready = 1'b0;
    req_sw(32'h3008, 32'hCAFEF00D);
    push_wait("hit_push", 3);
    idle();
    ld_addr = 32'h300B; #1;
    chk("ld_hit_same_word", 32'(ld_hit), 32'(1));
    ld_addr = 32'h300C; #1;
    chk("ld_hit_next_word", 32'(ld_hit), 32'(0));
    ld_addr = 32'h3008;
    mem_ready = 1'b1;
    cycle();
    chk("ld_hit_after_pop", 32'(ld_hit), 32'(0));
    ld_addr = '0;

    // Asynchronous reset mid-drain discards queued stores
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_sw(32'h400 + 32'(4 * k), 32'hC0000000 + 32'(k));
      push_wait("rst_fill", 3);
    end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mem_valid", 32'(mem_valid), 32'(0));
    chk("async_empty", 32'(empty), 32'(1));
    chk("async_ready", 32'(ready), 32'(1));
    chk("async_mem_be", 32'(mem_be), 32'(0));
    mem_ready = 1'b1;
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    apply(vecs[5]);
    push_wait("post_reset_push", 3);
    idle();
    drain("post_reset_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
